my_reduce_pipe: RTL and testbench

- Parametrised, pipelined N-operand bitwise reduction unit. It succeeds the fixed six-input structural AND tree.
- Reduces NUM_IN operands of WIDTH bits with a selectable op (AND/OR/XOR/NAND) through a balanced binary tree, with one register stage per tree level.
- Uses a valid/ready handshake with full backpressure.
- Serves ALU/branch-condition and flag logic wherever wide multi-operand reductions are needed without lengthening the critical path.

---
 rtl/my_reduce_pipe.sv | 120 ++++++++++++
 tb/tb_my_reduce_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_reduce_pipe.sv
// Pipelined NUM_IN-operand bitwise reduction (AND/OR/XOR/NAND) over a balanced
// binary tree, one register stage per tree level, with valid/ready backpressure.
module my_reduce_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [1:0]                out_op,
  output logic                      out_zero
);

  localparam int LEVELS = $clog2(NUM_IN);
  // One spare slot past the last operand keeps the pair index 2j+1 in range.
  localparam int SLOTS  = NUM_IN + 1;

  // Handshake: a transfer happens on an edge where valid && ready. The whole
  // pipe advances together when the output register is empty or being drained,
  // so in_ready is exactly that advance enable and bubbles are never collapsed.

  function automatic int level_count(input int k);
    return (NUM_IN + (1 << k) - 1) >> k;
  endfunction

  function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [1:0]       op);
    case (op)
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a & b;
    endcase
  endfunction

  logic             adv;
  logic [WIDTH-1:0] in_word    [SLOTS];
  logic [WIDTH-1:0] src        [SLOTS];
  logic [1:0]       src_op;
  logic [WIDTH-1:0] stage_data [LEVELS][SLOTS];
  logic [WIDTH-1:0] nxt_data   [LEVELS][SLOTS];
  logic             stage_valid[LEVELS];
  logic [1:0]       stage_op   [LEVELS];
  logic [1:0]       nxt_op     [LEVELS];
  logic             load_en    [LEVELS];
  logic             nxt_zero;
  logic             out_zero_q;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_word
    assign in_word[i] = in_data[i*WIDTH +: WIDTH];
  end
  assign in_word[NUM_IN] = '0;

  assign adv       = !stage_valid[LEVELS-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = stage_valid[LEVELS-1];
  assign out_data  = stage_data[LEVELS-1][0];
  assign out_op    = stage_op[LEVELS-1];
  assign out_zero  = out_zero_q;

  always_comb begin
    src_op   = in_op;
    nxt_zero = 1'b0;
    for (int j = 0; j < SLOTS; j++) src[j] = '0;
    for (int k = 0; k < LEVELS; k++) begin
      nxt_op[k]  = 2'b00;
      load_en[k] = 1'b0;
      for (int j = 0; j < SLOTS; j++) nxt_data[k][j] = '0;
    end
    for (int k = 0; k < LEVELS; k++) begin
      if (k == 0) begin
        for (int j = 0; j < SLOTS; j++) src[j] = in_word[j];
        src_op     = in_op;
        load_en[k] = in_valid;
      end else begin
        for (int j = 0; j < SLOTS; j++) src[j] = stage_data[(k == 0) ? 0 : k - 1][j];
        src_op     = stage_op[(k == 0) ? 0 : k - 1];
        load_en[k] = stage_valid[(k == 0) ? 0 : k - 1];
      end
      nxt_op[k] = src_op;
      // Odd leftover element at a level passes through untouched, no padding.
      for (int j = 0; j < (NUM_IN + 1) / 2; j++) begin
        if (2*j + 1 < level_count(k))
          nxt_data[k][j] = combine(src[2*j], src[2*j+1], src_op);
        else if (2*j < level_count(k))
          nxt_data[k][j] = src[2*j];
      end
    end
    // NAND is an AND tree with a single inversion at the very last level.
    if (src_op == 2'b11) nxt_data[LEVELS-1][0] = ~nxt_data[LEVELS-1][0];
    nxt_zero = (nxt_data[LEVELS-1][0] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LEVELS; k++) begin
        stage_valid[k] <= 1'b0;
        stage_op[k]    <= 2'b00;
        for (int j = 0; j < SLOTS; j++) stage_data[k][j] <= '0;
      end
      out_zero_q <= 1'b1;
    end else if (adv) begin
      for (int k = 0; k < LEVELS; k++) begin
        stage_valid[k] <= load_en[k];
        if (load_en[k]) begin
          stage_op[k] <= nxt_op[k];
          for (int j = 0; j < SLOTS; j++) stage_data[k][j] <= nxt_data[k][j];
        end
      end
      if (load_en[LEVELS-1]) out_zero_q <= nxt_zero;
    end
  end

endmodule

// File: tb/tb_my_reduce_pipe.sv
// Bench for my_reduce_pipe: directed and random traffic scored against a
// linear-fold reference model, with latency, stall-hold and reset checks.
module tb_my_reduce_pipe;
  localparam int WIDTH  = 32;
  localparam int NUM_IN = 6;
  localparam int LEVELS = 3;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_op;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_op;
  logic                    out_zero;

  my_reduce_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_op(out_op), .out_zero(out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               n_in = 0;
  int               n_out = 0;
  bit               strict_lat = 0;
  logic [WIDTH+1:0] exp_q[$];
  int               lat_q[$];
  logic [WIDTH-1:0] last_out;
  bit               hold_pend = 0;
  logic [WIDTH+2:0] hold_val;

  // Reference: a plain left-to-right fold; all three ops are associative.
  function automatic logic [WIDTH-1:0] model(input logic [NUM_IN*WIDTH-1:0] d,
                                             input logic [1:0] op);
    logic [WIDTH-1:0] acc;
    acc = d[WIDTH-1:0];
    for (int i = 1; i < NUM_IN; i++) begin
      case (op)
        2'b01:   acc = acc | d[i*WIDTH +: WIDTH];
        2'b10:   acc = acc ^ d[i*WIDTH +: WIDTH];
        default: acc = acc & d[i*WIDTH +: WIDTH];
      endcase
    end
    if (op == 2'b11) acc = ~acc;
    return acc;
  endfunction

  function automatic logic [NUM_IN*WIDTH-1:0] rand_data();
    logic [NUM_IN*WIDTH-1:0] d;
    for (int i = 0; i < NUM_IN; i++) begin
      case ($urandom_range(0, 3))
        0:       d[i*WIDTH +: WIDTH] = '1;
        1:       d[i*WIDTH +: WIDTH] = '0;
        default: d[i*WIDTH +: WIDTH] = $urandom;
      endcase
    end
    return d;
  endfunction

  // One clock: sample/score at the falling edge, then step past the rising edge.
  task automatic cycle(output bit acc);
    logic [WIDTH+1:0] e;
    int a;
    @(negedge clk);
    acc = in_valid && in_ready && !rst;
    if (rst) begin
      exp_q.delete();
      lat_q.delete();
      hold_pend = 0;
    end else begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready_rule: in_ready=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (hold_pend) begin
        checks++;
        if ({out_valid, out_zero, out_op, out_data} !== {1'b1, hold_val}) begin
          errors++;
          $display("FAIL stall_hold: got v=%b z=%b op=%b d=%h expected v=1 z=%b op=%b d=%h",
                   out_valid, out_zero, out_op, out_data, hold_val[WIDTH+2], hold_val[WIDTH+1:WIDTH], hold_val[WIDTH-1:0]);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got op=%b d=%h expected no output", out_op, out_data);
        end else begin
          e = exp_q.pop_front();
          a = lat_q.pop_front();
          checks++;
          if ({out_op, out_data} !== e) begin
            errors++;
            $display("FAIL result: got op=%b d=%h expected op=%b d=%h", out_op, out_data, e[WIDTH+1:WIDTH], e[WIDTH-1:0]);
          end
          checks++;
          if (out_zero !== (e[WIDTH-1:0] == '0)) begin
            errors++;
            $display("FAIL out_zero: got %b expected %b", out_zero, e[WIDTH-1:0] == '0);
          end
          if (strict_lat) begin
            checks++;
            if (cyc - a != LEVELS) begin
              errors++;
              $display("FAIL latency: got %0d expected %0d", cyc - a, LEVELS);
            end
          end
          last_out = out_data;
          n_out++;
        end
      end
      if (acc) begin
        exp_q.push_back({in_op, model(in_data, in_op)});
        lat_q.push_back(cyc);
        n_in++;
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_zero, out_op, out_data};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(acc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic send_one(input logic [NUM_IN*WIDTH-1:0] d, input logic [1:0] op,
                          input logic [WIDTH-1:0] expv);
    bit acc;
    strict_lat = 1;
    in_valid   = 1'b1;
    in_data    = d;
    in_op      = op;
    out_ready  = 1'b1;
    cycle(acc);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept: got 0 expected 1");
    end
    drain();
    checks++;
    if (last_out !== expv) begin
      errors++;
      $display("FAIL directed op=%b: got %h expected %h", op, last_out, expv);
    end
    strict_lat = 0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_op     = 2'b01;
    in_data   = rand_data();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      in_data = rand_data();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_zero !== 1'b1 || out_data !== '0 || out_op !== 2'b00) begin
        errors++;
        $display("FAIL reset_state: got v=%b z=%b d=%h op=%b expected v=0 z=1 d=0 op=00",
                 out_valid, out_zero, out_data, out_op);
      end
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [NUM_IN*WIDTH-1:0] d;
    d = '1;
    d[5*WIDTH +: WIDTH] = 32'hFFFF_0FFF;
    send_one(d, 2'b00, 32'hFFFF_0FFF);
    send_one(d, 2'b11, 32'h0000_F000);
    for (int i = 0; i < NUM_IN; i++) d[i*WIDTH +: WIDTH] = 32'd1 << i;
    send_one(d, 2'b10, 32'h0000_003F);
    d[5*WIDTH +: WIDTH] = '0;
    send_one(d, 2'b01, 32'h0000_001F);
    d = '0;
    d[5*WIDTH +: WIDTH] = 32'h80;
    send_one(d, 2'b01, 32'h0000_0080);
  endtask

  task automatic test_zero_flag();
    logic [NUM_IN*WIDTH-1:0] d;
    d = '1;
    d[2*WIDTH +: WIDTH] = '0;
    send_one(d, 2'b00, 32'h0);
    send_one('0, 2'b01, 32'h0);
  endtask

  task automatic test_back_to_back();
    bit acc;
    int start_out;
    start_out  = n_out;
    strict_lat = 1;
    out_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom_range(0, 3));
      in_data  = rand_data();
      cycle(acc);
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL throughput: txn %0d got accept=0 expected 1", i);
      end
    end
    drain();
    strict_lat = 0;
    checks++;
    if (n_out - start_out != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 8", n_out - start_out);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int idx;
    int start_out;
    idx       = 0;
    start_out = n_out;
    in_op     = 2'($urandom_range(0, 3));
    in_data   = rand_data();
    for (int k = 0; k < 60 && (idx < 8 || exp_q.size() > 0); k++) begin
      in_valid  = (idx < 8);
      out_ready = !(k >= 5 && k < 9);
      if (!out_ready) begin
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
      end
      cycle(acc);
      if (acc) begin
        idx++;
        in_op   = 2'($urandom_range(0, 3));
        in_data = rand_data();
      end
    end
    checks++;
    if (idx != 8 || exp_q.size() != 0 || n_out - start_out != 8) begin
      errors++;
      $display("FAIL backpressure_count: got in=%0d out=%0d pending=%0d expected 8 8 0",
               idx, n_out - start_out, exp_q.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_random();
    bit acc;
    int idx;
    idx = 0;
    for (int k = 0; k < 400 && (idx < 40 || exp_q.size() > 0); k++) begin
      if (idx >= 40 || $urandom_range(0, 3) == 0) in_valid = 1'b0;
      else in_valid = 1'b1;
      in_op     = 2'($urandom_range(0, 3));
      in_data   = rand_data();
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) idx++;
    end
    checks++;
    if (idx != 40 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_count: got in=%0d pending=%0d expected 40 0", idx, exp_q.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    bit acc;
    int start_out;
    logic [NUM_IN*WIDTH-1:0] d;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom_range(0, 3));
      in_data  = rand_data();
      cycle(acc);
    end
    start_out = n_out;
    rst      = 1'b1;
    in_valid = 1'b0;
    cycle(acc);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle(acc);
    checks++;
    if (n_out != start_out) begin
      errors++;
      $display("FAIL midflight_drop: got %0d outputs expected 0", n_out - start_out);
    end
    d = '1;
    d[3*WIDTH +: WIDTH] = 32'h1234_5678;
    send_one(d, 2'b11, ~32'h1234_5678);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_zero_flag();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
